// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline's memory-access stage.
//   ResultSrc encodings   : which value the write-back mux selects.
//   funct3 load/store     : access size and signedness.
//   memState_e            : memory-access FSM states.
package riscv_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE,
    WAIT
  } memState_e;

endpackage

// File: rtl/load_extend.sv
// Load lane selection and extension.
//   rdata  : raw 32-bit word returned by memory
//   offset : byte offset of the access within the word
//   funct3 : load type (LB/LH/LW/LBU/LHU)
//   data   : lane shifted down to bit 0, then sign- or zero-extended
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data = {24'h0, shifted[7:0]};
      F3_LHU:  data = {16'h0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: drives a ready/valid data-memory port, stalls the
// front of the pipeline while memory is busy, and owns the MEM/WB register.
//   clk, reset (async, active-high)
//   *M inputs    : control and data from the EX/MEM register
//   mem_*        : data-memory request/response port
//   StallM       : holds IF/ID/EX/MEM registers while memory is not ready
//   *W outputs   : MEM/WB register contents
module mem_access_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic        MisalignW
);

  memState_e   state;
  logic        heldWe;
  logic [31:0] heldAddr, heldWdata;
  logic [3:0]  heldBe;
  logic [2:0]  heldFunct3;
  logic [1:0]  heldOffset;

  logic        isLoad, isStore, isMem, legalF3, alignErr, misalign, waiting, misalignNow;
  logic [3:0]  reqBe;
  logic [31:0] reqWdata, loadData;

  // A store wins if both flags are set, so a load is only a non-writing MEM result.
  assign isStore = MemWriteM;
  assign isLoad  = (ResultSrcM == RESULT_MEM) && !MemWriteM;
  assign isMem   = isStore || isLoad;
  assign waiting = (state == WAIT);

  always_comb begin
    if (isStore) legalF3 = funct3M inside {F3_SB, F3_SH, F3_SW};
    else         legalF3 = funct3M inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    case (funct3M[1:0])
      2'b00: begin
        alignErr = 1'b0;
        reqBe    = 4'b0001 << ALUResultM[1:0];
        reqWdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        alignErr = ALUResultM[0];
        reqBe    = 4'b0011 << ALUResultM[1:0];
        reqWdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        alignErr = (ALUResultM[1:0] != 2'b00);
        reqBe    = 4'b1111;
        reqWdata = WriteDataM;
      end
    endcase
  end

  assign misalign    = isMem && (!legalF3 || alignErr);
  // In WAIT the access was already accepted as aligned; ignore the held inputs.
  assign misalignNow = !waiting && misalign;

  // While waiting, drive the request from the captured copy so it stays stable.
  assign mem_req   = !reset && (waiting || (isMem && !misalign));
  assign mem_we    = mem_req && (waiting ? heldWe : isStore);
  assign mem_addr  = waiting ? heldAddr  : {ALUResultM[31:2], 2'b00};
  assign mem_wdata = waiting ? heldWdata : reqWdata;
  assign mem_be    = waiting ? heldBe    : reqBe;
  assign StallM    = mem_req && !mem_ready;

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .offset (waiting ? heldOffset : ALUResultM[1:0]),
    .funct3 (waiting ? heldFunct3 : funct3M),
    .data   (loadData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      heldWe     <= 1'b0;
      heldAddr   <= 32'h0;
      heldWdata  <= 32'h0;
      heldBe     <= 4'h0;
      heldFunct3 <= 3'h0;
      heldOffset <= 2'h0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req && !mem_ready) begin
            state      <= WAIT;
            heldWe     <= isStore;
            heldAddr   <= {ALUResultM[31:2], 2'b00};
            heldWdata  <= reqWdata;
            heldBe     <= reqBe;
            heldFunct3 <= funct3M;
            heldOffset <= ALUResultM[1:0];
          end
        end
        WAIT: begin
          if (mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: a stall loads a bubble, other fields hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ReadDataW  <= 32'h0;
      ALUResultW <= 32'h0;
      RdW        <= 5'h0;
      PCPlus4W   <= 32'h0;
      MisalignW  <= 1'b0;
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      MisalignW  <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM && !misalignNow;
      ResultSrcW <= ResultSrcM;
      ReadDataW  <= loadData;
      ALUResultW <= ALUResultM;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      MisalignW  <= misalignNow;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a table of single-cycle accesses
// with mem_ready high, plus hand-written stall, store-wait and reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic        mem_req, mem_we, mem_ready, StallM;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RdW;

  int total = 0;
  int bad   = 0;

  mem_access_stage dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .funct3M    (funct3M),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .StallM     (StallM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .RdW        (RdW),
    .PCPlus4W   (PCPlus4W),
    .MisalignW  (MisalignW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regWrite;
    logic        memWrite;
    logic [1:0]  resultSrc;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic        expReq;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expBe;
    logic        expWe;
    logic        expRegW;
    logic        expMis;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mw, input logic [1:0] rs, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic rdy, input logic [31:0] rdata);
    RegWriteM  = rw;
    MemWriteM  = mw;
    ResultSrcM = rs;
    ALUResultM = a;
    WriteDataM = wd;
    funct3M    = f3;
    RdM        = rd;
    PCPlus4M   = pc4;
    mem_ready  = rdy;
    mem_rdata  = rdata;
  endtask

  task automatic chkWZero(input string tag);
    chk({tag, ".RegWriteW"},  {31'h0, RegWriteW}, 32'h0);
    chk({tag, ".MisalignW"},  {31'h0, MisalignW}, 32'h0);
    chk({tag, ".ResultSrcW"}, {30'h0, ResultSrcW}, 32'h0);
    chk({tag, ".ReadDataW"},  ReadDataW, 32'h0);
    chk({tag, ".ALUResultW"}, ALUResultW, 32'h0);
    chk({tag, ".RdW"},        {27'h0, RdW}, 32'h0);
    chk({tag, ".PCPlus4W"},   PCPlus4W, 32'h0);
  endtask

  initial begin
    //              rw mw rs     alu           wdata         f3      rd    pc4       rdata
    //              req addr       wdata         be       we  regW mis read
    vecs[0]  = '{1, 0, 2'b01, 32'h100, 32'h0, 3'b010, 5'd1, 32'h1004, 32'hDEADBEEF,
                 1, 32'h100, 32'h0, 4'b1111, 0, 1, 0, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 2'b01, 32'h103, 32'h0, 3'b000, 5'd2, 32'h2004, 32'h80FF0000,
                 1, 32'h100, 32'h0, 4'b1000, 0, 1, 0, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 2'b01, 32'h103, 32'h0, 3'b100, 5'd3, 32'h2008, 32'h80FF0000,
                 1, 32'h100, 32'h0, 4'b1000, 0, 1, 0, 32'h00000080};
    vecs[3]  = '{0, 1, 2'b00, 32'h202, 32'h1234ABCD, 3'b001, 5'd0, 32'h3004, 32'h0,
                 1, 32'h200, 32'hABCDABCD, 4'b1100, 1, 0, 0, 32'h0};
    vecs[4]  = '{0, 1, 2'b00, 32'h001, 32'h000000A5, 3'b000, 5'd0, 32'h3008, 32'h0,
                 1, 32'h000, 32'hA5A5A5A5, 4'b0010, 1, 0, 0, 32'h0};
    vecs[5]  = '{0, 1, 2'b00, 32'h00C, 32'hCAFEF00D, 3'b010, 5'd0, 32'h300C, 32'h0,
                 1, 32'h00C, 32'hCAFEF00D, 4'b1111, 1, 0, 0, 32'h0};
    vecs[6]  = '{1, 0, 2'b01, 32'h102, 32'h0, 3'b001, 5'd4, 32'h4004, 32'h80010000,
                 1, 32'h100, 32'h0, 4'b1100, 0, 1, 0, 32'hFFFF8001};
    vecs[7]  = '{1, 0, 2'b01, 32'h100, 32'h0, 3'b101, 5'd5, 32'h4008, 32'h0000F00F,
                 1, 32'h100, 32'h0, 4'b0011, 0, 1, 0, 32'h0000F00F};
    vecs[8]  = '{1, 0, 2'b01, 32'h102, 32'h0, 3'b010, 5'd6, 32'h5004, 32'h0,
                 0, 32'h0, 32'h0, 4'b0000, 0, 0, 1, 32'h0};
    vecs[9]  = '{1, 0, 2'b00, 32'h12345678, 32'h0, 3'b000, 5'd7, 32'h6004, 32'h0,
                 0, 32'h0, 32'h0, 4'b0000, 0, 1, 0, 32'h0};
    vecs[10] = '{1, 0, 2'b01, 32'h101, 32'h0, 3'b001, 5'd8, 32'h7004, 32'h0,
                 0, 32'h0, 32'h0, 4'b0000, 0, 0, 1, 32'h0};
    vecs[11] = '{0, 1, 2'b00, 32'h200, 32'h11, 3'b011, 5'd0, 32'h7008, 32'h0,
                 0, 32'h0, 32'h0, 4'b0000, 0, 0, 1, 32'h0};
    vecs[12] = '{1, 0, 2'b01, 32'h200, 32'h0, 3'b110, 5'd9, 32'h700C, 32'h0,
                 0, 32'h0, 32'h0, 4'b0000, 0, 0, 1, 32'h0};
    vecs[13] = '{1, 0, 2'b10, 32'h55, 32'h0, 3'b000, 5'd10, 32'h888, 32'h0,
                 0, 32'h0, 32'h0, 4'b0000, 0, 1, 0, 32'h0};
    vecs[14] = '{1, 0, 2'b01, 32'h102, 32'h0, 3'b000, 5'd11, 32'h9004, 32'h007F0000,
                 1, 32'h100, 32'h0, 4'b0100, 0, 1, 0, 32'h0000007F};

    // Reset with an aligned load on the inputs: no request, W outputs cleared.
    reset = 1'b1;
    drive(1, 0, 2'b01, 32'h100, 32'h0, 3'b010, 5'd1, 32'h1004, 1'b1, 32'h0);
    #1;
    chk("rst.mem_req", {31'h0, mem_req}, 32'h0);
    chkWZero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].regWrite, vecs[i].memWrite, vecs[i].resultSrc, vecs[i].alu, vecs[i].wdata,
            vecs[i].f3, vecs[i].rd, vecs[i].pc4, 1'b1, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d.mem_req", i), {31'h0, mem_req}, {31'h0, vecs[i].expReq});
      chk($sformatf("v%0d.StallM", i), {31'h0, StallM}, 32'h0);
      if (vecs[i].expReq) begin
        chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].expAddr);
        chk($sformatf("v%0d.mem_be", i), {28'h0, mem_be}, {28'h0, vecs[i].expBe});
        chk($sformatf("v%0d.mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].expWe});
        if (vecs[i].expWe) chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].expWdata);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.RegWriteW", i), {31'h0, RegWriteW}, {31'h0, vecs[i].expRegW});
      chk($sformatf("v%0d.MisalignW", i), {31'h0, MisalignW}, {31'h0, vecs[i].expMis});
      chk($sformatf("v%0d.ReadDataW", i), ReadDataW, vecs[i].expRead);
      chk($sformatf("v%0d.ALUResultW", i), ALUResultW, vecs[i].alu);
      chk($sformatf("v%0d.RdW", i), {27'h0, RdW}, {27'h0, vecs[i].rd});
      chk($sformatf("v%0d.PCPlus4W", i), PCPlus4W, vecs[i].pc4);
      chk($sformatf("v%0d.ResultSrcW", i), {30'h0, ResultSrcW}, {30'h0, vecs[i].resultSrc});
      @(negedge clk);
    end

    // LW with mem_ready low for three cycles, then data on the fourth.
    drive(1, 0, 2'b01, 32'h040, 32'h0, 3'b010, 5'd12, 32'hA004, 1'b0, 32'hBAD0BAD0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("st%0d.mem_req", k), {31'h0, mem_req}, 32'h1);
      chk($sformatf("st%0d.StallM", k), {31'h0, StallM}, 32'h1);
      chk($sformatf("st%0d.mem_addr", k), mem_addr, 32'h040);
      chk($sformatf("st%0d.mem_be", k), {28'h0, mem_be}, 32'hF);
      chk($sformatf("st%0d.mem_we", k), {31'h0, mem_we}, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("st%0d.RegWriteW", k), {31'h0, RegWriteW}, 32'h0);
      chk($sformatf("st%0d.MisalignW", k), {31'h0, MisalignW}, 32'h0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h11223344;
    #1;
    chk("st3.StallM", {31'h0, StallM}, 32'h0);
    chk("st3.mem_req", {31'h0, mem_req}, 32'h1);
    chk("st3.mem_addr", mem_addr, 32'h040);
    @(posedge clk);
    #1;
    chk("st3.RegWriteW", {31'h0, RegWriteW}, 32'h1);
    chk("st3.ReadDataW", ReadDataW, 32'h11223344);
    chk("st3.RdW", {27'h0, RdW}, 32'd12);
    @(negedge clk);

    // SW held for one wait cycle: write strobe and data stay up.
    drive(0, 1, 2'b00, 32'h020, 32'h5566_7788, 3'b010, 5'd0, 32'hB004, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sw.wait.mem_we", {31'h0, mem_we}, 32'h1);
    chk("sw.wait.mem_wdata", mem_wdata, 32'h55667788);
    chk("sw.wait.StallM", {31'h0, StallM}, 32'h1);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("sw.done.ALUResultW", ALUResultW, 32'h020);
    @(negedge clk);

    // Reset during WAIT abandons the access.
    drive(1, 0, 2'b01, 32'h080, 32'h0, 3'b010, 5'd13, 32'hC004, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rw.pre.StallM", {31'h0, StallM}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rw.mem_req", {31'h0, mem_req}, 32'h0);
    chkWZero("rw");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A50000;
    #1;
    chk("rw.post.mem_req", {31'h0, mem_req}, 32'h1);
    chk("rw.post.StallM", {31'h0, StallM}, 32'h0);
    @(posedge clk);
    #1;
    chk("rw.post.RegWriteW", {31'h0, RegWriteW}, 32'h1);
    chk("rw.post.ReadDataW", ReadDataW, 32'hA5A50000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: RegWriteM in 1, MemWriteM in 1, ResultSrcM in 2, which are the control inputs from the EX/MEM register.
REQ-003 SHALL have: ALUResultM in 32 (address/result), WriteDataM in 32, funct3M in 3, RdM in 5, PCPlus4M in 32.
REQ-004 SHALL have: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_be out 4, mem_ready in 1, mem_rdata in 32.
REQ-005 SHALL have: StallM out 1, which holds IF/ID/EX/MEM registers while set.
REQ-006 SHALL have MEM/WB outputs: RegWriteW out 1, ResultSrcW out 2, ReadDataW out 32, ALUResultW out 32, RdW out 5, PCPlus4W out 32, MisalignW out 1.

Function
REQ-007 SHALL treat ResultSrcM==2'b01 as a load and MemWriteM==1 as a store; any other combination is a non-memory op.
REQ-008 SHALL implement FSM states IDLE and WAIT.
REQ-009 In IDLE with an aligned access, the block SHALL assert mem_req combinationally in the same cycle.
REQ-010 In IDLE with an aligned access and mem_ready=1, the block SHALL complete the access in that cycle; with mem_ready=0 it SHALL move to WAIT.
REQ-011 In WAIT, the block SHALL hold mem_req, mem_we, mem_addr, mem_wdata and mem_be stable, and SHALL return to IDLE on the first cycle with mem_ready=1.
REQ-012 StallM SHALL equal mem_req AND NOT mem_ready.
REQ-013 On every clock edge with StallM=1, the MEM/WB outputs SHALL load a bubble: RegWriteW=0, MisalignW=0, other fields don't-care but held.
REQ-014 On every clock edge with StallM=0, the MEM/WB outputs SHALL capture the M-stage values; ReadDataW SHALL capture the extended mem_rdata.
REQ-015 Address and byte enables: mem_addr = {ALUResultM[31:2],2'b00}; byte: mem_be = 4'b0001<<a[1:0]; half: 4'b0011<<a[1:0]; word: 4'b1111, where a = ALUResultM.
REQ-016 Store data: SB replicates byte[7:0] x4; SH replicates half[15:0] x2; SW passes the data through.
REQ-017 Load extension: the selected lane SHALL be shifted by a[1:0]*8; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-018 Misaligned condition: half with a[0]=1, word with a[1:0]!=0, or funct3 not legal for the access type (load: 000,001,010,100,101; store: 000,001,010).
REQ-019 A misaligned access SHALL NOT assert mem_req, SHALL NOT stall, and SHALL register RegWriteW=0 and MisalignW=1 for one cycle.
REQ-020 Non-memory ops SHALL pass through in one cycle with mem_req=0.
REQ-021 mem_req SHALL NOT be asserted while reset is high.

Reset
REQ-022 Reset SHALL force state IDLE and drive all W outputs to 0.
REQ-023 Reset asserted in WAIT SHALL abandon the access: mem_req drops with reset, and no write-back occurs.
REQ-024 On the first cycle after reset release, mem_req SHALL follow the M inputs per REQ-009/REQ-020.

Structure
REQ-025 Shared package riscv_pkg SHALL hold: ResultSrc encodings (ALU=00, MEM=01, PC4=10), funct3 load/store constants, and the FSM state enum.
REQ-026 Load lane selection and extension SHALL be a combinational sub-module load_extend (inputs rdata, offset, funct3; output data).

Verification
REQ-027 LW at 0x100 with mem_ready=1 and mem_rdata=0xDEADBEEF -> no stall; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
REQ-028 LB at 0x103 with mem_rdata=0x80FF0000 -> ReadDataW=0xFFFFFF80; the same access as LBU -> ReadDataW=0x00000080.
REQ-029 SH at 0x202 with WriteDataM=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, mem_addr=0x200.
REQ-030 LW with mem_ready low for 3 cycles -> StallM=1 for 3 cycles with stable request, RegWriteW=0 during those cycles; data is captured on the 4th cycle.
REQ-031 LW at 0x102 -> mem_req=0, StallM=0; next cycle MisalignW=1, RegWriteW=0.
REQ-032 Reset pulsed during WAIT -> mem_req=0 immediately; all W outputs are 0 and the FSM is in IDLE afterwards.
